// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared FSM states, flag indices and width helpers for fp_mult_iterative.
package fp_mult_pkg;

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    localparam int FLAG_ZERO = 3;
    localparam int FLAG_PINF = 2;
    localparam int FLAG_NINF = 1;
    localparam int FLAG_NAN  = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic logic [3:0] flag_bit(input int idx);
        return 4'(1 << idx);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify: flags an operand magnitude (exp, man) as zero, infinity or NaN; subnormals read as zero.
module fp_classify #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] op_i,
    output logic                   is_zero_o,
    output logic                   is_inf_o,
    output logic                   is_nan_o
);
    logic exp_ones, man_zero;

    assign exp_ones  = &op_i[EXP_W+MAN_W-1 -: EXP_W];
    assign man_zero  = op_i[MAN_W-1:0] == '0;
    assign is_zero_o = op_i[EXP_W+MAN_W-1 -: EXP_W] == '0;
    assign is_inf_o  = exp_ones && man_zero;
    assign is_nan_o  = exp_ones && !man_zero;

endmodule

// File: rtl/fp_mult_iterative.sv
// fp_mult_iterative: multi-cycle shift-add floating-point multiplier with valid/ready handshakes.
// Define FP_MULT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the mantissa truncates.
module fp_mult_iterative
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] dataA,
    input  logic [EXP_W+MAN_W:0] dataB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] dataR,
    output logic [3:0]           casesspecial
);
    localparam int W  = fp_width(EXP_W, MAN_W);
    localparam int PW = 2 * (MAN_W + 1);
    localparam int CW = $clog2(MAN_W + 1);
    localparam logic [EXP_W+1:0] BIAS_V = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic [EXP_W+1:0] EMAX   = (EXP_W+2)'((1 << EXP_W) - 1);

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, data_r_q;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q;
    logic [3:0]    flags_q;
    logic          in_ready_q, out_valid_q;

    logic zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op_i(dataA[W-2:0]), .is_zero_o(zero_a), .is_inf_o(inf_a), .is_nan_o(nan_a)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op_i(dataB[W-2:0]), .is_zero_o(zero_b), .is_inf_o(inf_b), .is_nan_o(nan_b)
    );

    // Special-operand result, resolved at accept in NaN > inf > zero priority
    logic         in_sign, spec_nan, spec_inf, is_spec;
    logic [W-1:0] spec_r;
    logic [3:0]   spec_f;

    always_comb begin
        in_sign  = dataA[W-1] ^ dataB[W-1];
        spec_nan = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
        spec_inf = inf_a | inf_b;
        is_spec  = spec_nan | spec_inf | zero_a | zero_b;
        spec_r   = spec_nan ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
                 : spec_inf ? {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                 : {in_sign, {(W-1){1'b0}}};
        spec_f   = spec_nan ? flag_bit(FLAG_NAN)
                 : spec_inf ? flag_bit(in_sign ? FLAG_NINF : FLAG_PINF)
                 : flag_bit(FLAG_ZERO);
    end

    logic [MAN_W:0] b_full;

    always_comb begin
        b_full = {1'b1, b_q[MAN_W-1:0]};
        acc_d  = acc_q + (b_full[cnt_q] ? (PW'({1'b1, a_q[MAN_W-1:0]}) << cnt_q) : '0);
    end

    logic             hi, rnd, carry, sign_q, ovf, unf;
    logic [MAN_W-1:0] man_t, man_n;
    logic [MAN_W:0]   man_sum;
    logic [EXP_W+1:0] exp_n;
    logic [W-1:0]     norm_r;
    logic [3:0]       norm_f;

    // Exponent kept in EXP_W+2 bits so its MSB acts as the sign of an underflowed result
    always_comb begin
        hi     = acc_q[PW-1];
        sign_q = a_q[W-1] ^ b_q[W-1];
        man_t  = hi ? acc_q[PW-2 -: MAN_W] : acc_q[PW-3 -: MAN_W];
`ifdef FP_MULT_ROUND_NEAREST_EN
        rnd    = hi ? acc_q[MAN_W] & ((|acc_q[MAN_W-1:0]) | man_t[0])
                    : acc_q[MAN_W-1] & ((|acc_q[MAN_W-2:0]) | man_t[0]);
`else
        rnd    = 1'b0;
`endif
        man_sum = {1'b0, man_t} + (MAN_W+1)'(rnd);
        carry   = man_sum[MAN_W];
        man_n   = man_sum[MAN_W-1:0];
        exp_n   = {2'b00, a_q[W-2 -: EXP_W]} + {2'b00, b_q[W-2 -: EXP_W]} - BIAS_V
                + (EXP_W+2)'(hi) + (EXP_W+2)'(carry);
        ovf     = !exp_n[EXP_W+1] && exp_n >= EMAX;
        unf     = exp_n[EXP_W+1] || exp_n == '0;
        norm_r  = ovf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                : unf ? {sign_q, {(W-1){1'b0}}}
                : {sign_q, exp_n[EXP_W-1:0], man_n};
        norm_f  = ovf ? flag_bit(sign_q ? FLAG_NINF : FLAG_PINF)
                : unf ? flag_bit(FLAG_ZERO)
                : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_r_q    <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready_q) begin
                    a_q        <= dataA;
                    b_q        <= dataB;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    if (is_spec) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        data_r_q    <= spec_r;
                        flags_q     <= spec_f;
                    end else begin
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MAN_W)) state_q <= NORM;
                end
                NORM: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    data_r_q    <= norm_r;
                    flags_q     <= norm_f;
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign dataR        = data_r_q;
    assign casesspecial = flags_q;

endmodule

// File: tb/tb_fp_mult_iterative.sv
// tb_fp_mult_iterative: directed vectors against an arithmetic reference model for FP32 and FP16 builds.
module tb_fp_mult_iterative;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv, ir, ov, ordy;
    logic [31:0] da, db, dr;
    logic [3:0]  cs;
    logic        iv16, ir16, ov16, ordy16;
    logic [15:0] da16, db16, dr16;
    logic [3:0]  cs16;

    fp_mult_iterative dut32 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .dataA(da), .dataB(db),
        .out_valid(ov), .out_ready(ordy), .dataR(dr), .casesspecial(cs)
    );

    fp_mult_iterative #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .dataA(da16), .dataB(db16),
        .out_valid(ov16), .out_ready(ordy16), .dataR(dr16), .casesspecial(cs16)
    );

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_r_q[$];
    logic [3:0]  exp_f_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: full-width integer product, then normalise/round/range-check on the real value
    function automatic void model(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
        longint one, emax, bias, ea, eb, ma, mb, s, p, m, e;
        int sh;
        bit za, zb, ia, ib, na, nb;
        one  = 1;
        emax = (one << ew) - 1;
        bias = (one << (ew - 1)) - 1;
        ea   = (longint'(a) >> mw) & emax;
        eb   = (longint'(b) >> mw) & emax;
        ma   = longint'(a) & ((one << mw) - 1);
        mb   = longint'(b) & ((one << mw) - 1);
        s    = ((longint'(a) ^ longint'(b)) >> (ew + mw)) & 1;
        za = ea == 0;  zb = eb == 0;
        ia = ea == emax && ma == 0;  ib = eb == emax && mb == 0;
        na = ea == emax && ma != 0;  nb = eb == emax && mb != 0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r = 32'((emax << mw) | (one << (mw - 1)));
            f = 4'b0001;
            return;
        end
        if (ia || ib) begin
            r = 32'((s << (ew + mw)) | (emax << mw));
            f = (s != 0) ? 4'b0010 : 4'b0100;
            return;
        end
        if (za || zb) begin
            r = 32'(s << (ew + mw));
            f = 4'b1000;
            return;
        end
        p  = ((one << mw) + ma) * ((one << mw) + mb);
        e  = ea + eb - bias;
        sh = mw;
        if (p >= (one << (2 * mw + 1))) begin
            e++;
            sh = mw + 1;
        end
        m = p >> sh;
`ifdef FP_MULT_ROUND_NEAREST_EN
        begin
            longint rem, half;
            rem  = p - (m << sh);
            half = one << (sh - 1);
            if (rem > half || (rem == half && m[0])) m++;
        end
`endif
        if (m == (one << (mw + 1))) begin
            m = m >> 1;
            e++;
        end
        if (e >= emax) begin
            r = 32'((s << (ew + mw)) | (emax << mw));
            f = (s != 0) ? 4'b0010 : 4'b0100;
        end else if (e <= 0) begin
            r = 32'(s << (ew + mw));
            f = 4'b1000;
        end else begin
            r = 32'((s << (ew + mw)) | (e << mw) | (m - (one << mw)));
            f = 4'b0000;
        end
    endfunction

    // Every cycle the FP32 result is valid it must match the oldest outstanding model entry
    always @(negedge clk) begin
        if (!reset && ov) begin
            chk("busy_in_ready", 64'(ir), 64'(0));
            if (exp_r_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(ov), 64'(0));
            end else begin
                chk("model_dataR", 64'(dr), 64'(exp_r_q[0]));
                chk("model_flags", 64'(cs), 64'(exp_f_q[0]));
                if (ordy) begin
                    void'(exp_r_q.pop_front());
                    void'(exp_f_q.pop_front());
                end
            end
        end
    end

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic [3:0] ef, input int lat, input int hold);
        logic [31:0] mr;
        logic [3:0]  mf;
        int n;
        model(8, 23, a, b, mr, mf);
        chk("model_pin", {28'h0, mr, mf}, {28'h0, er, ef});
        n = 0;
        while (!ir && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        exp_r_q.push_back(mr);
        exp_f_q.push_back(mf);
        da = a; db = b; iv = 1'b1; ordy = (hold == 0);
        @(posedge clk); #1;
        iv = 1'b0;
        n = 1;
        while (!ov && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("dataR", 64'(dr), 64'(er));
        chk("flags", 64'(cs), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(ov), 64'(1));
            chk("hold_dataR", 64'(dr), 64'(er));
            chk("hold_in_ready", 64'(ir), 64'(0));
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 64'(ov), 64'(0));
        chk("release_in_ready", 64'(ir), 64'(1));
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                        input logic [3:0] ef, input int lat);
        logic [31:0] mr;
        logic [3:0]  mf;
        int n;
        model(5, 10, 32'(a), 32'(b), mr, mf);
        chk("model16_pin", {28'h0, mr, mf}, {44'h0, er, ef});
        da16 = a; db16 = b; iv16 = 1'b1; ordy16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 1;
        while (!ov16 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency16", 64'(n), 64'(lat));
        chk("dataR16", 64'(dr16), 64'(er));
        chk("flags16", 64'(cs16), 64'(ef));
        chk("dataR16_model", 64'(dr16), 64'(mr[15:0]));
        @(posedge clk); #1;
        chk("release16_valid", 64'(ov16), 64'(0));
    endtask

    initial begin
        logic bad;
        reset = 1'b1;
        iv = 1'b0; ordy = 1'b0; da = '0; db = '0;
        iv16 = 1'b0; ordy16 = 1'b0; da16 = '0; db16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(ir), 64'(1));
        chk("reset_out_valid", 64'(ov), 64'(0));
        chk("reset_dataR", 64'(dr), 64'(0));
        chk("reset_flags", 64'(cs), 64'(0));
        chk("reset_in_ready16", 64'(ir16), 64'(1));
        reset = 1'b0;
        @(posedge clk); #1;

        op32(32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 4'b0000, 26, 0);
        op32(32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000, 26, 5);
        op32(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0001, 1, 0);
        op32(32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0010, 1, 0);
        op32(32'h7FC0F0F0, 32'hFF800000, 32'h7FC00000, 4'b0001, 1, 0);
        op32(32'h80000000, 32'h40400000, 32'h80000000, 4'b1000, 1, 0);
        op32(32'h71800000, 32'h71800000, 32'h7F800000, 4'b0100, 26, 0);
        op32(32'hF1800000, 32'h71800000, 32'hFF800000, 4'b0010, 26, 0);
        op32(32'h0D800000, 32'h0D800000, 32'h00000000, 4'b1000, 26, 0);
        op32(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26, 0);
        op32(32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, 26, 0);
`ifdef FP_MULT_ROUND_NEAREST_EN
        op32(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0000, 26, 0);
`else
        op32(32'h3FC00000, 32'h3F800001, 32'h3FC00001, 4'b0000, 26, 0);
`endif

        // Reset in the 10th MULT cycle must discard the operation
        da = 32'h40FC0000; db = 32'h3E400000; iv = 1'b1; ordy = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midop_reset_in_ready", 64'(ir), 64'(1));
        chk("midop_reset_out_valid", 64'(ov), 64'(0));
        exp_r_q.delete();
        exp_f_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ov || !ir) bad = 1'b1;
        end
        chk("no_output_after_reset", 64'(bad), 64'(0));
        op32(32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000, 26, 0);

        op16(16'h4000, 16'h4200, 16'h4600, 4'b0000, 13);
        op16(16'h7C00, 16'h0000, 16'h7E00, 4'b0001, 1);
        op16(16'h7800, 16'h7800, 16'h7C00, 4'b0100, 13);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
